// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag layout for alu_seq and its multiplier.
package alu_pkg;

    localparam logic [3:0] OP_PASS_A = 4'b0000;
    localparam logic [3:0] OP_PASS_B = 4'b0001;
    localparam logic [3:0] OP_NEG_A  = 4'b0010;
    localparam logic [3:0] OP_NEG_B  = 4'b0011;
    localparam logic [3:0] OP_CMP_GT = 4'b0100;
    localparam logic [3:0] OP_XNOR   = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b0110;
    localparam logic [3:0] OP_SUB    = 4'b0111;
    localparam logic [3:0] OP_MUL    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned FLAG_ZERO    = 0;
    localparam int unsigned FLAG_NEG     = 1;
    localparam int unsigned FLAG_CARRY   = 2;
    localparam int unsigned FLAG_OVF     = 3;
    localparam int unsigned FLAG_ILLEGAL = 4;
    localparam int unsigned FLAG_COUNT   = 5;

    typedef logic [FLAG_COUNT-1:0] flags_t;

    function automatic flags_t pack_flags(
        input logic zero,
        input logic neg,
        input logic carry,
        input logic ovf,
        input logic illegal
    );
        flags_t f;
        f               = '0;
        f[FLAG_ZERO]    = zero;
        f[FLAG_NEG]     = neg;
        f[FLAG_CARRY]   = carry;
        f[FLAG_OVF]     = ovf;
        f[FLAG_ILLEGAL] = illegal;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// done pulses during the final iteration with the finished product on product.
module alu_seq_mul #(
    parameter int WIDTH      = 6,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    // product is the accumulator after this cycle's step, so the caller can
    // capture it on the same edge that retires the last iteration.
    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        done    = busy && (cnt == CW'(MUL_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and status flags.
// Define ALU_SEQ_MUL_EN to compile in the multi-cycle multiplier (opcode 1000).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       fxn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [3:0]         op_f;
    logic [WIDTH-1:0]   alu_x;
    flags_t             alu_flags;
    flags_t             mul_flags;
    flags_t             flags;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_illegal;

`ifdef ALU_SEQ_MUL_EN
    always_comb begin
        is_mul = (fxn == OP_MUL);
    end

    alu_seq_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    always_comb begin
        is_mul      = 1'b0;
        mul_done    = 1'b0;
        mul_product = '0;
    end
`endif

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state == DONE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? BUSY : EXEC;
                end
            end
            EXEC: state_next = DONE;
            BUSY: begin
                if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = is_mul ? BUSY : EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        alu_x       = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        sum         = {1'b0, op_a} + {1'b0, op_b};
        diff        = {1'b0, op_a} - {1'b0, op_b};
        case (op_f)
            OP_PASS_A: alu_x = op_a;
            OP_PASS_B: alu_x = op_b;
            OP_NEG_A: begin
                alu_x   = '0 - op_a;
                alu_ovf = (op_a == MSB_ONLY);
            end
            OP_NEG_B: begin
                alu_x   = '0 - op_b;
                alu_ovf = (op_b == MSB_ONLY);
            end
            OP_CMP_GT: alu_x = {{(WIDTH-1){1'b0}}, (op_a > op_b)};
            OP_XNOR:   alu_x = ~(op_a ^ op_b);
            OP_ADD: begin
                alu_x     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_x     = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                            (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            // MUL only reaches this path when the multiplier is compiled out.
            default: alu_illegal = 1'b1;
        endcase
        alu_flags = pack_flags(alu_x == '0, alu_x[WIDTH-1], alu_carry, alu_ovf, alu_illegal);
        mul_flags = pack_flags(mul_product[WIDTH-1:0] == '0, mul_product[WIDTH-1],
                               |mul_product[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            op_f  <= '0;
            x     <= '0;
            flags <= '0;
        end else begin
            if (accept) begin
                op_a <= a;
                op_b <= b;
                op_f <= fxn;
            end
            if (state == EXEC) begin
                x     <= alu_x;
                flags <= alu_flags;
            end else if ((state == BUSY) && mul_done) begin
                x     <= mul_product[WIDTH-1:0];
                flags <= mul_flags;
            end
        end
    end

    always_comb begin
        zero    = flags[FLAG_ZERO];
        neg     = flags[FLAG_NEG];
        carry   = flags[FLAG_CARRY];
        ovf     = flags[FLAG_OVF];
        illegal = flags[FLAG_ILLEGAL];
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=6) against an integer reference model.
module tb_alu_seq;

    localparam int W = 6;
    localparam int M = 1 << W;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   fxn = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] x;
    logic         zero, neg, carry, ovf, illegal;

    int checks = 0;
    int errors = 0;
    int last_x;
    int last_fl;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .fxn(fxn), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_flags();
        return 32'({illegal, ovf, carry, neg, zero});
    endfunction

    // Reference: signed views and plain integer arithmetic on 0..M-1 values.
    function automatic void model(input int ai, input int bi, input int fi,
                                  output int xr, output int fl, output int lat);
        int sa, sb, ss, r;
        bit c, o, il;
        c = 0; o = 0; il = 0; r = 0; ss = 0; lat = 2;
        sa = (ai >= M/2) ? ai - M : ai;
        sb = (bi >= M/2) ? bi - M : bi;
        case (fi)
            0: r = ai;
            1: r = bi;
            2: begin r = (M - ai) % M; o = (ai == M/2); end
            3: begin r = (M - bi) % M; o = (bi == M/2); end
            4: r = (ai > bi) ? 1 : 0;
            5: r = (M - 1) - (ai ^ bi);
            6: begin
                r = (ai + bi) % M; c = (ai + bi) >= M;
                ss = sa + sb; o = (ss > M/2 - 1) || (ss < -M/2);
            end
            7: begin
                r = (ai - bi + M) % M; c = (ai < bi);
                ss = sa - sb; o = (ss > M/2 - 1) || (ss < -M/2);
            end
            8: begin
                if (MUL_ON) begin
                    r = (ai * bi) % M; c = (ai * bi) >= M; lat = W + 1;
                end else begin
                    il = 1;
                end
            end
            default: il = 1;
        endcase
        xr = r;
        fl = (int'(il) << 4) | (int'(o) << 3) | (int'(c) << 2) |
             (int'(r >= M/2) << 1) | int'(r == 0);
    endfunction

    task automatic run_op(input int ai, input int bi, input int fi, input int stall);
        int xr, fl, lat_exp, lat, n;
        model(ai, bi, fi, xr, fl, lat_exp);
        @(negedge clk);
        a = W'(ai); b = W'(bi); fxn = 4'(fi); in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // keep offering junk while the op is in flight; none of it may be taken
        a = W'($urandom); b = W'($urandom); fxn = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'(lat_exp));
        check("x", 32'(x), 32'(xr));
        check("flags", dut_flags(), 32'(fl));
        last_x = int'(x);
        last_fl = int'(dut_flags());
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_x", 32'(x), 32'(xr));
            check("hold_flags", dut_flags(), 32'(fl));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("released", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    int tp_a[4], tp_b[4], tp_f[4];
    int xr, fl, lat_exp, ai, bi, fi, r;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_flags", dut_flags(), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // directed plan items
        run_op(31, 1, 6, 0);
        check("plan_add_x", 32'(last_x), 32'd32);
        check("plan_add_flags", 32'(last_fl), 32'b01010);
        run_op(5, 7, 7, 0);
        check("plan_sub_x", 32'(last_x), 32'd62);
        check("plan_sub_flags", 32'(last_fl), 32'b00110);
        run_op(32, 0, 2, 0);
        check("plan_neg_x", 32'(last_x), 32'd32);
        check("plan_neg_flags", 32'(last_fl), 32'b01010);
        run_op(3, 4, 10, 0);
        check("plan_illegal_x", 32'(last_x), 32'd0);
        check("plan_illegal_flags", 32'(last_fl), 32'b10001);
`ifdef ALU_SEQ_MUL_EN
        run_op(7, 9, 8, 0);
        check("plan_mul_x", 32'(last_x), 32'd63);
        check("plan_mul_flags", 32'(last_fl), 32'b00010);
        run_op(8, 8, 8, 1);
        check("plan_mul_ovfl_x", 32'(last_x), 32'd0);
        check("plan_mul_ovfl_flags", 32'(last_fl), 32'b00101);
        run_op(0, 45, 8, 0);
`else
        run_op(7, 9, 8, 0);
        check("plan_mul_off_x", 32'(last_x), 32'd0);
        check("plan_mul_off_flags", 32'(last_fl), 32'b10001);
`endif

        // backpressure, then same-cycle accept on out_ready
        @(negedge clk);
        a = W'(3); b = W'(4); fxn = 4'(6); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_x", 32'(x), 32'd7);
        a = W'(50); b = W'(50); fxn = 4'(6); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_x", 32'(x), 32'd7);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        a = W'(20); b = W'(3); fxn = 4'(7); out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_next_exec", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_x", 32'(x), 32'd17);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // back-to-back single-cycle ops with out_ready high: one result per 2 cycles
        for (int k = 0; k < 4; k++) begin
            tp_a[k] = $urandom_range(0, M - 1);
            tp_b[k] = $urandom_range(0, M - 1);
            tp_f[k] = $urandom_range(0, 7);
        end
        @(negedge clk);
        a = W'(tp_a[0]); b = W'(tp_b[0]); fxn = 4'(tp_f[0]); in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("tp_exec", 32'(out_valid), 32'd0);
            if (k < 3) begin
                a = W'(tp_a[k+1]); b = W'(tp_b[k+1]); fxn = 4'(tp_f[k+1]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            model(tp_a[k], tp_b[k], tp_f[k], xr, fl, lat_exp);
            check("tp_valid", 32'(out_valid), 32'd1);
            check("tp_x", 32'(x), 32'(xr));
            check("tp_flags", dut_flags(), 32'(fl));
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("tp_idle", 32'(out_valid), 32'd0);

        // reset in the middle of an operation
        run_op(5, 4, 6, 0);
        @(negedge clk);
        a = W'(7); b = W'(9); fxn = MUL_ON ? 4'd8 : 4'd6; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_x", 32'(x), 32'd0);
        check("midrst_flags", dut_flags(), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("postrst_no_valid", 32'(out_valid), 32'd0);
            check("postrst_in_ready", 32'(in_ready), 32'd1);
        end

        // randomized ops, biased towards boundary operands
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            ai = (r == 0) ? 0 : (r == 1) ? M/2 : (r == 2) ? M - 1 : $urandom_range(0, M - 1);
            bi = $urandom_range(0, M - 1);
            fi = $urandom_range(0, 15);
            run_op(ai, bi, fi, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
